// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared CIM widths, activation limits, types and packer state encoding
package cim_pkg;
  localparam int NEURON_W = 12;
  localparam int ACT_W    = 9;
  localparam int WEIGHT_W = 2;
  localparam int N_LANES  = 8;
  localparam int IDX_W    = $clog2(N_LANES);
  localparam int SAT_W    = $clog2(N_LANES + 1);

  localparam int ACT_MAX_I = 2 ** (ACT_W - 1) - 1;
  localparam int ACT_MIN_I = -(2 ** (ACT_W - 1));

  typedef logic signed [NEURON_W-1:0] neuron_t;
  typedef logic signed [ACT_W-1:0]    act_t;

  localparam act_t ACT_MAX = act_t'(ACT_MAX_I);
  localparam act_t ACT_MIN = act_t'(ACT_MIN_I);

  typedef enum logic {FILL, EMIT} pack_state_e;
endpackage

// File: rtl/cim_act_packer_if.sv
// rtl/cim_act_packer_if.sv - neuron-sample input and activation-vector output handshakes of the packer
interface cim_act_packer_if;
  import cim_pkg::*;

  logic                     s_valid;
  logic                     s_ready;
  neuron_t                  s_data;
  logic                     flush;
  logic                     m_valid;
  logic                     m_ready;
  logic [N_LANES*ACT_W-1:0] m_act;
  logic [SAT_W-1:0]         m_sat;

  modport slave (
    input  s_valid, s_data, flush, m_ready,
    output s_ready, m_valid, m_act, m_sat
  );

  modport master (
    output s_valid, s_data, flush, m_ready,
    input  s_ready, m_valid, m_act, m_sat
  );
endinterface

// File: rtl/cim_requant.sv
// rtl/cim_requant.sv - round, arithmetic shift, optional ReLU (CIM_RELU_EN) and saturate one neuron output
module cim_requant import cim_pkg::*; #(
  parameter int SHIFT = 2
) (
  input  neuron_t data_i,
  output act_t    act_o,
  output logic    sat_o
);
  localparam int RND_I = (SHIFT > 0) ? 2 ** (SHIFT - 1) : 0;
  localparam logic signed [NEURON_W:0] RND = (NEURON_W + 1)'(RND_I);
  localparam logic signed [NEURON_W:0] HI  = (NEURON_W + 1)'(ACT_MAX_I);
  localparam logic signed [NEURON_W:0] LO  = (NEURON_W + 1)'(ACT_MIN_I);

  logic signed [NEURON_W:0] sum;
  logic signed [NEURON_W:0] shifted;
  logic signed [NEURON_W:0] clipped_in;

  // One extra bit keeps the rounding add of a full-scale input from wrapping.
  assign sum     = {data_i[NEURON_W-1], data_i} + RND;
  assign shifted = sum >>> SHIFT;

`ifdef CIM_RELU_EN
  assign clipped_in = shifted[NEURON_W] ? '0 : shifted;
`else
  assign clipped_in = shifted;
`endif

  always_comb begin
    act_o = clipped_in[ACT_W-1:0];
    sat_o = 1'b0;
    if (clipped_in > HI) begin
      act_o = ACT_MAX;
      sat_o = 1'b1;
    end else if (clipped_in < LO) begin
      act_o = ACT_MIN;
      sat_o = 1'b1;
    end
  end
endmodule

// File: rtl/cim_act_packer.sv
// rtl/cim_act_packer.sv - packs requantized neuron outputs into N_LANES-wide activation vectors
// Build option: CIM_RELU_EN selects ReLU before saturation in cim_requant.
module cim_act_packer import cim_pkg::*; #(
  parameter int SHIFT = 2
) (
  input logic             clk,
  input logic             rst_n,
  cim_act_packer_if.slave bus
);
  pack_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  act_t             act_q [N_LANES];
  logic [SAT_W-1:0] sat_q;
  logic             m_valid_q;

  act_t rq_act;
  logic rq_sat;
  logic accept;
  logic last_lane;

  cim_requant #(.SHIFT(SHIFT)) u_requant (
    .data_i (bus.s_data),
    .act_o  (rq_act),
    .sat_o  (rq_sat)
  );

  assign accept    = bus.s_valid && (state_q == FILL);
  assign last_lane = (idx_q == IDX_W'(N_LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      sat_q     <= '0;
      m_valid_q <= 1'b0;
      for (int k = 0; k < N_LANES; k++) act_q[k] <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            act_q[idx_q] <= rq_act;
            sat_q        <= sat_q + SAT_W'(rq_sat);
          end
          if ((accept && last_lane) || (bus.flush && (accept || idx_q != '0))) begin
            // Lanes past the last stored sample are padded so a flushed vector never carries stale data.
            for (int k = 0; k < N_LANES; k++) begin
              if (IDX_W'(k) > idx_q || (IDX_W'(k) == idx_q && !accept)) act_q[k] <= '0;
            end
            state_q   <= EMIT;
            m_valid_q <= 1'b1;
            idx_q     <= '0;
          end else if (accept) begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        EMIT: begin
          if (bus.m_ready) begin
            state_q   <= FILL;
            m_valid_q <= 1'b0;
            sat_q     <= '0;
            for (int k = 0; k < N_LANES; k++) act_q[k] <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.s_ready = (state_q == FILL);
  assign bus.m_valid = m_valid_q;
  assign bus.m_sat   = sat_q;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign bus.m_act[g*ACT_W +: ACT_W] = act_q[g];
  end
endmodule
